// File: rtl/bootrom_fetch_adapter.sv
// Boot ROM fetch adapter: serves 32-bit instruction fetches from a single-line
// buffer and refills that line from the boot ROM on a miss.
module bootrom_fetch_adapter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fetch_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] fetch_req_addr_i,
  output logic                  fetch_req_ready_o,
  output logic                  fetch_resp_valid_o,
  output logic [31:0]           fetch_resp_data_o,
  output logic                  fetch_resp_err_o,
  input  logic                  invalidate_i,
  output logic                  brom_req_valid_o,
  output logic [ADDR_WIDTH-1:0] brom_req_address_o,
  input  logic                  brom_ready_i,
  input  logic [LINE_WIDTH-1:0] brom_resp_data_i,
  input  logic                  brom_resp_valid_i
);

  localparam int TAG_W = ADDR_WIDTH - 4;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;

  state_t                  state, next_state;
  logic                    line_valid;
  logic [TAG_W-1:0]        line_tag;
  logic [LINE_WIDTH-1:0]   line_data;
  logic [ADDR_WIDTH-1:2]   req_word_addr;
  logic [TAG_W-1:0]        brom_line;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    resp_err;
  logic                    accept, hit, fill, timeout;
  logic                    unused_addr_bits;

  // Byte offset within a word never matters for whole-word fetches.
  assign unused_addr_bits = ^fetch_req_addr_i[1:0];

  // Hit uses the registered line_valid, so a coincident invalidate cannot spoil it.
  assign accept  = fetch_req_valid_i && fetch_req_ready_o;
  assign hit     = line_valid && (line_tag == fetch_req_addr_i[ADDR_WIDTH-1:4]);
  assign fill    = (state == WAIT_RESP) && brom_resp_valid_i;
  assign timeout = (state == WAIT_RESP) && !brom_resp_valid_i &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign brom_req_address_o = {brom_line, 4'b0000};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = hit ? RESPOND : ISSUE;
      ISSUE:     if (brom_ready_i) next_state = WAIT_RESP;
      WAIT_RESP: if (fill || timeout) next_state = RESPOND;
      RESPOND:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Response fields are forced to zero outside the single RESPOND cycle.
  always_comb begin
    fetch_req_ready_o  = 1'b0;
    brom_req_valid_o   = 1'b0;
    fetch_resp_valid_o = 1'b0;
    fetch_resp_err_o   = 1'b0;
    fetch_resp_data_o  = '0;
    case (state)
      IDLE:    fetch_req_ready_o = rstn;
      ISSUE:   brom_req_valid_o = brom_ready_i;
      RESPOND: begin
        fetch_resp_valid_o = 1'b1;
        fetch_resp_err_o   = resp_err;
        if (!resp_err)
          fetch_resp_data_o = line_data[{req_word_addr[3:2], 5'd0} +: 32];
      end
      default: ;
    endcase
  end

  // Invalidate has priority over a fill so the line ends up empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_valid <= 1'b0;
      wait_cnt   <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (invalidate_i) line_valid <= 1'b0;
      else if (fill)    line_valid <= 1'b1;
      wait_cnt <= (state == WAIT_RESP) ? wait_cnt + 1'b1 : '0;
      if (accept)       resp_err <= 1'b0;
      else if (timeout) resp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)         req_word_addr <= fetch_req_addr_i[ADDR_WIDTH-1:2];
    if (accept && !hit) brom_line     <= fetch_req_addr_i[ADDR_WIDTH-1:4];
    if (fill) begin
      line_data <= brom_resp_data_i;
      line_tag  <= req_word_addr[ADDR_WIDTH-1:4];
    end
  end

endmodule

// File: tb/tb_bootrom_fetch_adapter.sv
// Self-checking bench for bootrom_fetch_adapter: directed table, reset corner
// case, and random fetches checked against a line-buffer reference model.
module tb_bootrom_fetch_adapter;

  localparam int AW     = 24;
  localparam int LW     = 128;
  localparam int TMO    = 255;
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          fetch_req_valid_i;
  logic [AW-1:0] fetch_req_addr_i;
  logic          fetch_req_ready_o;
  logic          fetch_resp_valid_o;
  logic [31:0]   fetch_resp_data_o;
  logic          fetch_resp_err_o;
  logic          invalidate_i;
  logic          brom_req_valid_o;
  logic [AW-1:0] brom_req_address_o;
  logic          brom_ready_i;
  logic [LW-1:0] brom_resp_data_i;
  logic          brom_resp_valid_i;

  always #5 clk = ~clk;

  bootrom_fetch_adapter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .fetch_req_valid_i(fetch_req_valid_i), .fetch_req_addr_i(fetch_req_addr_i),
    .fetch_req_ready_o(fetch_req_ready_o), .fetch_resp_valid_o(fetch_resp_valid_o),
    .fetch_resp_data_o(fetch_resp_data_o), .fetch_resp_err_o(fetch_resp_err_o),
    .invalidate_i(invalidate_i), .brom_req_valid_o(brom_req_valid_o),
    .brom_req_address_o(brom_req_address_o), .brom_ready_i(brom_ready_i),
    .brom_resp_data_i(brom_resp_data_i), .brom_resp_valid_i(brom_resp_valid_i)
  );

  typedef struct {
    logic [23:0] addr;
    int          stall;
    int          delay;
    bit          respond;
    bit          inv_accept;
    bit          inv_resp;
    bit          exp_hit;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          ready;
    int          strobes;
    logic [23:0] brom_addr;
    int          lat;
    logic [31:0] data;
    bit          err;
    int          ready_viol;
    int          idle_noise;
    bit          stray_quiet;
  } obs_t;

  int          errors = 0;
  int          checks = 0;
  bit          m_valid = 1'b0;
  logic [19:0] m_tag = '0;
  vec_t        table_v [11];
  logic [23:0] lines [4] = '{24'h000100, 24'h000200, 24'h012340, 24'hFFFFF0};

  function automatic logic [127:0] rom_line(input logic [23:0] line);
    if (line == 24'h000100) return 128'h33333333_22222222_11111111_00000000;
    return {line, 8'd3, line, 8'd2, line, 8'd1, line, 8'd0};
  endfunction

  function automatic logic [31:0] rom_word(input logic [23:0] line, input int k);
    logic [127:0] l;
    l = rom_line(line);
    return l[k*32 +: 32];
  endfunction

  function automatic vec_t mk(input logic [23:0] addr, input int stall, input int delay,
                              input bit respond, input bit inv_a, input bit inv_r,
                              input bit hit, input logic [31:0] data, input bit err,
                              input int lat);
    vec_t v;
    v.addr = addr; v.stall = stall; v.delay = delay; v.respond = respond;
    v.inv_accept = inv_a; v.inv_resp = inv_r;
    v.exp_hit = hit; v.exp_data = data; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  // Reference model: a single remembered line, ROM contents known up front.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    r = v;
    r.exp_hit  = m_valid && (m_tag == v.addr[23:4]);
    r.exp_err  = !r.exp_hit && !v.respond;
    r.exp_data = r.exp_err ? 32'h0 : rom_word({v.addr[23:4], 4'h0}, int'(v.addr[3:2]));
    r.exp_lat  = r.exp_hit ? 1 : v.stall + 1 + (v.respond ? v.delay + 1 : TMO + 1);
    return r;
  endfunction

  task automatic update_model(input vec_t v);
    bit hit;
    hit = m_valid && (m_tag == v.addr[23:4]);
    if (v.inv_accept) m_valid = 1'b0;
    if (!hit && v.respond) begin
      m_tag   = v.addr[23:4];
      m_valid = !v.inv_resp;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
  task automatic apply_stimulus(input vec_t v, output obs_t o);
    int c, strobe_c;
    bit done;
    o.ready = 0; o.strobes = 0; o.brom_addr = '0; o.lat = -1; o.data = '0;
    o.err = 0; o.ready_viol = 0; o.idle_noise = 0; o.stray_quiet = 0;
    fetch_req_valid_i = 1'b1;
    fetch_req_addr_i  = v.addr;
    invalidate_i      = v.inv_accept;
    brom_ready_i      = (v.stall == 0);
    @(negedge clk);
    o.ready = fetch_req_ready_o;
    @(posedge clk); #1;
    fetch_req_valid_i = 1'b0;
    invalidate_i      = 1'b0;
    c = 1; strobe_c = -1; done = 0;
    while (!done && c <= BUDGET) begin
      brom_ready_i      = (c > v.stall);
      brom_resp_valid_i = v.respond && (strobe_c > 0) && (c == strobe_c + v.delay);
      brom_resp_data_i  = brom_resp_valid_i ? rom_line({v.addr[23:4], 4'h0})
                                            : {$urandom, $urandom, $urandom, $urandom};
      invalidate_i      = brom_resp_valid_i && v.inv_resp;
      @(negedge clk);
      if (brom_req_valid_o) begin
        o.strobes++;
        if (!brom_ready_i) o.ready_viol++;
        if (strobe_c < 0) begin
          strobe_c    = c;
          o.brom_addr = brom_req_address_o;
        end
      end
      if (fetch_resp_valid_o) begin
        o.lat  = c;
        o.data = fetch_resp_data_o;
        o.err  = fetch_resp_err_o;
        done   = 1;
      end else if (fetch_resp_data_o != 32'h0 || fetch_resp_err_o) begin
        o.idle_noise++;
      end
      @(posedge clk); #1;
      c++;
    end
    brom_resp_valid_i = 1'b0;
    invalidate_i      = 1'b0;
    brom_ready_i      = 1'b1;
    // A stray line arriving in IDLE must not disturb anything.
    brom_resp_valid_i = 1'b1;
    brom_resp_data_i  = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    o.stray_quiet = !fetch_resp_valid_o && !brom_req_valid_o && fetch_req_ready_o;
    @(posedge clk); #1;
    brom_resp_valid_i = 1'b0;
  endtask

  task automatic run_vector(input string tag, input vec_t v);
    obs_t o;
    apply_stimulus(v, o);
    check_output({tag, ".ready"}, o.ready, 1);
    check_output({tag, ".strobes"}, o.strobes, v.exp_hit ? 0 : 1);
    if (!v.exp_hit) check_output({tag, ".brom_addr"}, o.brom_addr, {v.addr[23:4], 4'h0});
    check_output({tag, ".latency"}, o.lat, v.exp_lat);
    check_output({tag, ".data"}, o.data, v.exp_data);
    check_output({tag, ".err"}, o.err, v.exp_err);
    check_output({tag, ".strobe_wo_ready"}, o.ready_viol, 0);
    check_output({tag, ".idle_noise"}, o.idle_noise, 0);
    check_output({tag, ".stray_ignored"}, o.stray_quiet, 1);
    update_model(v);
  endtask

  initial begin
    vec_t v;
    fetch_req_valid_i = 1'b0;
    fetch_req_addr_i  = '0;
    invalidate_i      = 1'b0;
    brom_ready_i      = 1'b1;
    brom_resp_valid_i = 1'b0;
    brom_resp_data_i  = '0;

    //               addr        stl dly rsp ia ir hit data          err lat
    table_v[0]  = mk(24'h000104,  0,  5, 1, 0, 0, 0, 32'h11111111, 0,   7);
    table_v[1]  = mk(24'h00010C,  0,  1, 1, 0, 0, 1, 32'h33333333, 0,   1);
    table_v[2]  = mk(24'h000100,  0,  1, 1, 0, 0, 1, 32'h00000000, 0,   1);
    table_v[3]  = mk(24'h000208, 10,  3, 1, 0, 0, 0, 32'h00020002, 0,  15);
    table_v[4]  = mk(24'h000300,  0,  1, 0, 0, 0, 0, 32'h00000000, 1, 257);
    table_v[5]  = mk(24'h000204,  0,  1, 1, 0, 0, 1, 32'h00020001, 0,   1);
    table_v[6]  = mk(24'h000404,  0,  2, 1, 0, 1, 0, 32'h00040001, 0,   4);
    table_v[7]  = mk(24'h000404,  0,  1, 1, 0, 0, 0, 32'h00040001, 0,   3);
    table_v[8]  = mk(24'h00040F,  0,  1, 1, 0, 0, 1, 32'h00040003, 0,   1);
    table_v[9]  = mk(24'h000400,  0,  1, 1, 1, 0, 1, 32'h00040000, 0,   1);
    table_v[10] = mk(24'h000400,  0,  1, 1, 0, 0, 0, 32'h00040000, 0,   3);

    #1 rstn = 1'b0;
    #1;
    check_output("reset.ready", fetch_req_ready_o, 0);
    check_output("reset.resp_valid", fetch_resp_valid_o, 0);
    check_output("reset.resp_data", fetch_resp_data_o, 0);
    check_output("reset.brom_valid", brom_req_valid_o, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_output("release.ready", fetch_req_ready_o, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      run_vector($sformatf("table%0d", i), table_v[i]);

    // Reset dropped while waiting on the boot ROM, with a late response around it.
    fetch_req_valid_i = 1'b1;
    fetch_req_addr_i  = 24'h000500;
    brom_ready_i      = 1'b1;
    @(posedge clk); #1;
    fetch_req_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rstn              = 1'b0;
    brom_resp_valid_i = 1'b1;
    brom_resp_data_i  = rom_line(24'h000500);
    #1;
    check_output("midrst.ready", fetch_req_ready_o, 0);
    check_output("midrst.resp_valid", fetch_resp_valid_o, 0);
    check_output("midrst.resp_data", fetch_resp_data_o, 0);
    check_output("midrst.resp_err", fetch_resp_err_o, 0);
    check_output("midrst.brom_valid", brom_req_valid_o, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_output("midrst.release_ready", fetch_req_ready_o, 1);
    check_output("midrst.late_resp", fetch_resp_valid_o, 0);
    @(posedge clk); #1;
    brom_resp_valid_i = 1'b0;
    m_valid = 1'b0;
    run_vector("midrst.refetch", predict(mk(24'h000104, 1, 2, 1, 0, 0, 0, 0, 0, 0)));

    for (int i = 0; i < 40; i++) begin
      v.addr       = lines[$urandom_range(0, 3)] | 24'($urandom_range(0, 15));
      v.stall      = $urandom_range(0, 3);
      v.delay      = $urandom_range(1, 8);
      v.respond    = ($urandom_range(0, 9) != 0);
      v.inv_accept = ($urandom_range(0, 6) == 0);
      v.inv_resp   = ($urandom_range(0, 4) == 0);
      run_vector($sformatf("rand%0d", i), predict(v));
      if ($urandom_range(0, 7) == 0) begin
        invalidate_i = 1'b1;
        @(posedge clk); #1;
        invalidate_i = 1'b0;
        m_valid = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
